// File: rtl/mult_pkg.sv
// Shared types and sizes for the shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    localparam int unsigned MULT_WIDTH = 64;
    localparam int unsigned MULT_CNT_W = 6;

endpackage

// File: rtl/fullAdder64.sv
// 64-bit ripple-carry adder shared with the execute-stage datapath.
module fullAdder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic carry;

    // Bit-serial carry ripple, LSB first.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 64; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/shift_add_multiplier64.sv
// Unsigned 64x64->128 multiplier, one shift-and-add step per clock, fixed 64-cycle latency.
module shift_add_multiplier64
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = MULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t      state, state_next;
    logic             accept;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] p_hi, p_lo;
    logic [WIDTH-1:0] p_hi_next, p_lo_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum;
    logic             cout;

    fullAdder64 u_adder (
        .a    (p_hi),
        .b    (m),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Shift mux: add-then-shift when the current multiplier bit is set, else plain shift.
    always_comb begin
        p_hi_next = {1'b0, p_hi[WIDTH-1:1]};
        p_lo_next = {p_hi[0], p_lo[WIDTH-1:1]};
        if (p_lo[0]) begin
            p_hi_next = {cout, sum[WIDTH-1:1]};
            p_lo_next = {sum[0], p_lo[WIDTH-1:1]};
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter and product registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            m     <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (accept) begin
                m    <= a;
                p_hi <= '0;
                p_lo <= b;
                cnt  <= '0;
            end else if (state == RUN) begin
                p_hi <= p_hi_next;
                p_lo <= p_lo_next;
                cnt  <= CNT_W'(cnt + 1'b1);
            end
        end
    end

    assign result_hi = p_hi;
    assign result_lo = p_lo;

endmodule

// File: tb/tb_shift_add_multiplier64.sv
// Directed self-checking bench for shift_add_multiplier64.
module tb_shift_add_multiplier64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result_lo;
    logic [63:0] result_hi;

    int tests_run    = 0;
    int tests_failed = 0;

    shift_add_multiplier64 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present operands, let one rising edge sample start, drop it.
    task automatic launch(input logic [63:0] x, input logic [63:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // k counts rising edges since the start edge; optionally re-pulses start at k == inject_k.
    task automatic wait_done(input int inject_k, output int k, output int busy_cnt);
        k        = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && k < 200) begin
            if (busy === 1'b1) busy_cnt++;
            start = 1'b0;
            if (k == inject_k) begin
                a     = 64'd9;
                b     = 64'd9;
                start = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [63:0] x, input logic [63:0] y,
                            input int inject_k, input logic [127:0] exp);
        int k, bc;
        launch(x, y);
        wait_done(inject_k, k, bc);
        check({tag, "_latency"}, 128'(k), 128'd64);
        check({tag, "_busy_cycles"}, 128'(bc), 128'd64);
        check({tag, "_busy_at_done"}, 128'(busy), 128'd0);
        check({tag, "_product"}, {result_hi, result_lo}, exp);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 128'(done), 128'd0);
        check({tag, "_held"}, {result_hi, result_lo}, exp);
    endtask

    initial begin
        int k, bc, seen;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_result", {result_hi, result_lo}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        run_case("3x5", 64'd3, 64'd5, -1, 128'd15);
        run_case("maxmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1,
                 {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
        run_case("carry_hi", 64'h8000_0000_0000_0000, 64'd2, -1, {64'd1, 64'd0});
        run_case("zero", 64'd0, 64'h1234, -1, 128'd0);
        run_case("ignored_start", 64'd7, 64'd6, 10, 128'd42);

        // Abort mid-run with an asynchronous reset between clock edges.
        launch(64'd7, 64'd7);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_result", {result_hi, result_lo}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("abort_no_done", 128'(seen), 128'd0);

        // Back-to-back: second start presented during the DONE cycle of the first.
        launch(64'd2, 64'd3);
        wait_done(-1, k, bc);
        check("b2b_first_latency", 128'(k), 128'd64);
        check("b2b_first_product", {result_hi, result_lo}, 128'd6);
        launch(64'd4, 64'd4);
        check("b2b_no_idle_busy", 128'(busy), 128'd1);
        check("b2b_no_idle_done", 128'(done), 128'd0);
        wait_done(-1, k, bc);
        check("b2b_second_latency", 128'(k), 128'd64);
        check("b2b_second_busy_cycles", 128'(bc), 128'd64);
        check("b2b_second_product", {result_hi, result_lo}, 128'd16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier64.md
# shift_add_multiplier64

Multi-cycle unsigned 64×64→128 multiplier for the execute stage. It drives operands into the 64-bit ripple adder each cycle and consumes its sum and carry. The block iterates one shift-and-add step per clock, so MUL (low half) and UMULH (high half) complete in a fixed 64-cycle latency. The pipeline stalls on `busy` and picks up the product on `done`.

## Interface
Parameters:
- `WIDTH`, default 64: operand width. Only 64 is supported, because the adder sub-module is fixed-width.
- `CNT_W`, default 6: iteration counter width, equal to log2(WIDTH).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a multiply. Sampled on the rising edge, and accepted only in IDLE or DONE.
- `a`, in, 64: multiplicand. Captured when `start` is accepted.
- `b`, in, 64: multiplier. Captured when `start` is accepted.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: high for exactly one cycle when the product is complete.
- `result_lo`, out, 64: product bits [63:0].
- `result_hi`, out, 64: product bits [127:64].

## Operation
- Registers:
  - `M[63:0]`: multiplicand.
  - `P_hi[63:0]`, `P_lo[63:0]`: partial product and remaining multiplier.
  - `cnt[5:0]`: iteration counter.
  - `state`.
- Accept, on `start` in IDLE or DONE:
  - M←a, P_hi←0, P_lo←b, cnt←0, state←RUN.
  - Inputs `a` and `b` are ignored at all other times.
- RUN step, every cycle:
  - The adder computes {cout, sum} = P_hi + M with cin=0.
  - If P_lo[0]=1: P_hi←{cout, sum[63:1]} and P_lo←{sum[0], P_lo[63:1]}.
  - If P_lo[0]=0: P_hi←{1'b0, P_hi[63:1]} and P_lo←{P_hi[0], P_lo[63:1]}.
  - cnt←cnt+1.
- FSM transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE when cnt==63, after that step completes.
  - DONE → RUN on `start`, otherwise DONE → IDLE.
- `start` in RUN is ignored. It is not queued and raises no error.
- Outputs:
  - `result_hi`=P_hi and `result_lo`=P_lo, driven directly from the registers.
  - They show the partial state during RUN.
  - They are valid from the `done` cycle until the next accepted `start`.
- Arithmetic is unsigned only. The product is exact, because the 65-bit {cout, sum} intermediate can never overflow 128 bits.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; `busy`=0, `done`=0.
  - `result_lo`=0, `result_hi`=0, M=0, cnt=0.
- Latency:
  - `start` is sampled at edge N.
  - `busy`=1 after edge N, through edge N+64 (64 cycles).
  - `done`=1 only between edges N+64 and N+65.
- `busy` and `done` are never high together.
- Back-to-back: `start` high during the DONE cycle is accepted at edge N+65. `busy` rises with no IDLE gap.
- `reset` asserted mid-RUN aborts the operation. Nothing is output and `done` does not pulse.
- Throughput is one product per 65 cycles at best.
- The critical path is the 64-bit carry ripple through the adder, plus the shift mux, in a single cycle.

## Structure
- Package `mult_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t`.
  - `localparam MULT_WIDTH = 64`.
  - `localparam MULT_CNT_W = 6`.
- Sub-module: one instance of the existing `fullAdder64`, with `a`=P_hi, `b`=M, `cin`=0. It is not duplicated or re-implemented.
- The FSM, counter and shift registers live in one `always_ff` with asynchronous reset. The next-state mux sits in `always_comb`.

## Test plan
- 3×5: a=3, b=5, start for 1 cycle.
  - `done` appears exactly 64 cycles after the start edge.
  - result_hi=0, result_lo=15.
  - `busy` is high for 64 cycles.
- Max×max: a=b=0xFFFF_FFFF_FFFF_FFFF.
  - result_hi=0xFFFF_FFFF_FFFF_FFFE, result_lo=0x0000_0000_0000_0001.
- Carry into high half: a=0x8000_0000_0000_0000, b=2 gives result_hi=1, result_lo=0.
- Zero operand: a=0, b=0x1234 gives a 128-bit zero result.
- Ignored start: start with a=7, b=6, then pulse start with a=9, b=9 at cycle 10 of RUN.
  - Result is 42.
  - `done` stays at the original 64-cycle position.
- Reset abort and back-to-back:
  - Assert reset mid-RUN: all outputs go to 0 immediately and `done` never pulses.
  - Then start 2×3 and assert start again in its DONE cycle with 4×4.
  - Results are 6, then 16 exactly 65 cycles later, with no IDLE cycle between.
